// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch target buffer.
// Direction counter arithmetic and PC index/tag split.
package bp_pkg;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_MAX = 2'd3;
  localparam ctr_t CTR_MIN = 2'd0;

  function automatic ctr_t ctr_next(ctr_t c, logic taken);
    if (taken) return (c == CTR_MAX) ? c : c + 2'd1;
    return (c == CTR_MIN) ? c : c - 2'd1;
  endfunction

  // Word-aligned split: pc[1:0] never participates in index or tag.
  function automatic logic [63:0] idx_of(logic [63:0] pc, int unsigned ib);
    return (pc >> 2) & ((64'd1 << ib) - 64'd1);
  endfunction

  function automatic logic [63:0] tag_of(logic [63:0] pc, int unsigned ib);
    return pc >> (ib + 2);
  endfunction

endpackage

// File: rtl/bp_btb_way.sv
// One BTB way: valid/tag/target/counter storage with a fetch read port.
// Latency: reads combinational, writes land on the next edge; no backpressure.
module bp_btb_way
  import bp_pkg::*;
#(
  parameter int PC         = 32,
  parameter int INDEX_BITS = 5,
  parameter int TAGW       = PC - INDEX_BITS - 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [INDEX_BITS-1:0] i_rd_idx,
  input  logic [TAGW-1:0]       i_rd_tag,
  output logic                  o_rd_hit,
  output logic                  o_rd_taken,
  output logic [PC-1:0]         o_rd_tgt,
  input  logic [INDEX_BITS-1:0] i_wr_idx,
  input  logic [TAGW-1:0]       i_wr_tag,
  output logic                  o_wr_vld,
  output logic                  o_wr_hit,
  output ctr_t                  o_wr_ctr,
  input  logic                  i_wr_vld_en,
  input  logic                  i_wr_tag_en,
  input  logic                  i_wr_tgt_en,
  input  logic                  i_wr_ctr_en,
  input  logic [PC-1:0]         i_wr_tgt,
  input  ctr_t                  i_wr_ctr
);

  localparam int SETS = 2 ** INDEX_BITS;

  logic [SETS-1:0] r_vld;
  logic [TAGW-1:0] r_tag [SETS];
  logic [PC-1:0]   r_tgt [SETS];
  ctr_t            r_ctr [SETS];

  assign o_rd_hit   = r_vld[i_rd_idx] && (r_tag[i_rd_idx] == i_rd_tag);
  assign o_rd_taken = r_ctr[i_rd_idx][1];
  assign o_rd_tgt   = r_tgt[i_rd_idx];

  // Write side exposes the current entry so the owner can read-modify-write.
  assign o_wr_vld = r_vld[i_wr_idx];
  assign o_wr_hit = r_vld[i_wr_idx] && (r_tag[i_wr_idx] == i_wr_tag);
  assign o_wr_ctr = r_ctr[i_wr_idx];

  always_ff @(posedge i_clk) begin
    if (i_rst) r_vld <= '0;
    else if (i_wr_vld_en) r_vld[i_wr_idx] <= 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_wr_tag_en) r_tag[i_wr_idx] <= i_wr_tag;
    if (i_wr_tgt_en) r_tgt[i_wr_idx] <= i_wr_tgt;
    if (i_wr_ctr_en) r_ctr[i_wr_idx] <= i_wr_ctr;
  end

endmodule

// File: rtl/bp_btb.sv
// Set-associative branch target buffer with 2-bit direction counters.
// Latency: fetch lookup combinational, training visible next cycle; no backpressure.
module bp_btb
  import bp_pkg::*;
#(
  parameter int   PC         = 32,
  parameter int   INDEX_BITS = 5,
  parameter int   WAYS       = 2,
  parameter ctr_t CTR_INIT   = 2'b10
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic [PC-1:0] fetch_pc_in,
  output logic          fetch_hit_out,
  output logic          fetch_taken_out,
  output logic [PC-1:0] fetch_target_out,
  input  logic          update_in,
  input  logic [PC-1:0] exmem_pc_in,
  input  logic          exmem_taken_in,
  input  logic [PC-1:0] exmem_target_in
);

  localparam int TAGW = PC - INDEX_BITS - 2;

  if (WAYS != 1 && WAYS != 2) begin : g_bad_ways
    $error("bp_btb: WAYS must be 1 or 2");
  end

  logic [INDEX_BITS-1:0] w_rd_idx, w_wr_idx;
  logic [TAGW-1:0]       w_rd_tag, w_wr_tag;

  assign w_rd_idx = INDEX_BITS'(idx_of(64'(fetch_pc_in), INDEX_BITS));
  assign w_rd_tag = TAGW'(tag_of(64'(fetch_pc_in), INDEX_BITS));
  assign w_wr_idx = INDEX_BITS'(idx_of(64'(exmem_pc_in), INDEX_BITS));
  assign w_wr_tag = TAGW'(tag_of(64'(exmem_pc_in), INDEX_BITS));

  logic [WAYS-1:0] w_rd_hit, w_rd_taken, w_wr_vld, w_wr_hit;
  logic [PC-1:0]   w_rd_tgt [WAYS];
  ctr_t            w_wr_ctr [WAYS];
  logic [WAYS-1:0] w_en_vld, w_en_tag, w_en_tgt, w_en_ctr;
  ctr_t            w_ctr_dat [WAYS];

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    bp_btb_way #(.PC(PC), .INDEX_BITS(INDEX_BITS), .TAGW(TAGW)) u_way (
      .i_clk       (clk_in),
      .i_rst       (rst_in),
      .i_rd_idx    (w_rd_idx),
      .i_rd_tag    (w_rd_tag),
      .o_rd_hit    (w_rd_hit[g]),
      .o_rd_taken  (w_rd_taken[g]),
      .o_rd_tgt    (w_rd_tgt[g]),
      .i_wr_idx    (w_wr_idx),
      .i_wr_tag    (w_wr_tag),
      .o_wr_vld    (w_wr_vld[g]),
      .o_wr_hit    (w_wr_hit[g]),
      .o_wr_ctr    (w_wr_ctr[g]),
      .i_wr_vld_en (w_en_vld[g]),
      .i_wr_tag_en (w_en_tag[g]),
      .i_wr_tgt_en (w_en_tgt[g]),
      .i_wr_ctr_en (w_en_ctr[g]),
      .i_wr_tgt    (exmem_target_in),
      .i_wr_ctr    (w_ctr_dat[g])
    );
  end

  // Fetch hit mux: tags are never duplicated, so an OR-reduce is exact.
  always_comb begin
    fetch_hit_out    = 1'b0;
    fetch_taken_out  = 1'b0;
    fetch_target_out = '0;
    for (int w = 0; w < WAYS; w++) begin
      fetch_hit_out    = fetch_hit_out | w_rd_hit[w];
      fetch_taken_out  = fetch_taken_out | (w_rd_hit[w] & w_rd_taken[w]);
      fetch_target_out = fetch_target_out | (w_rd_hit[w] ? w_rd_tgt[w] : '0);
    end
  end

  logic w_upd, w_upd_hit, w_alloc, w_victim;

  assign w_upd     = update_in & ~rst_in;
  assign w_upd_hit = |w_wr_hit;
  assign w_alloc   = w_upd & ~w_upd_hit & exmem_taken_in;

  if (WAYS == 2) begin : g_lru
    localparam int SETS = 2 ** INDEX_BITS;
    logic [SETS-1:0] r_lru;
    logic            w_touch;

    assign w_victim = !w_wr_vld[0] ? 1'b0 :
                      !w_wr_vld[1] ? 1'b1 : r_lru[w_wr_idx];
    assign w_touch  = w_upd_hit ? w_wr_hit[1] : w_victim;

    always_ff @(posedge clk_in) begin
      if (rst_in) r_lru <= '0;
      else if (w_upd_hit || w_alloc) begin
        if (w_upd) r_lru[w_wr_idx] <= ~w_touch;
      end
    end
  end else begin : g_dm
    assign w_victim = 1'b0;
  end

  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      logic sel_hit, sel_alloc;
      sel_hit      = w_upd & w_wr_hit[w];
      sel_alloc    = w_alloc & (w_victim == 1'(w));
      w_en_vld[w]  = sel_alloc;
      w_en_tag[w]  = sel_alloc;
      w_en_tgt[w]  = sel_alloc | (sel_hit & exmem_taken_in);
      w_en_ctr[w]  = sel_alloc | sel_hit;
      w_ctr_dat[w] = sel_alloc ? CTR_INIT : ctr_next(w_wr_ctr[w], exmem_taken_in);
    end
  end

endmodule

// File: tb/tb_bp_btb.sv
// Directed bench for bp_btb: reset, allocation, counters, LRU, same-cycle and reset-drop.
module tb_bp_btb;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] fetch_pc_in;
  logic        fetch_hit_out;
  logic        fetch_taken_out;
  logic [31:0] fetch_target_out;
  logic        update_in;
  logic [31:0] exmem_pc_in;
  logic        exmem_taken_in;
  logic [31:0] exmem_target_in;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk_in = ~clk_in;

  bp_btb dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .fetch_pc_in      (fetch_pc_in),
    .fetch_hit_out    (fetch_hit_out),
    .fetch_taken_out  (fetch_taken_out),
    .fetch_target_out (fetch_target_out),
    .update_in        (update_in),
    .exmem_pc_in      (exmem_pc_in),
    .exmem_taken_in   (exmem_taken_in),
    .exmem_target_in  (exmem_target_in)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Inputs change #1 after a rising edge so nothing races the clock.
  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    update_in       = 1'b1;
    exmem_pc_in     = pc;
    exmem_taken_in  = tk;
    exmem_target_in = tgt;
    @(posedge clk_in); #1;
    update_in = 1'b0;
  endtask

  task automatic look(input string tag, input logic [31:0] pc,
                      input logic ehit, input logic etk, input logic [31:0] etgt);
    fetch_pc_in = pc;
    #1;
    chk({tag, ".hit"},    32'(fetch_hit_out),   32'(ehit));
    chk({tag, ".taken"},  32'(fetch_taken_out), 32'(etk));
    chk({tag, ".target"}, fetch_target_out,     etgt);
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    rst_in = 1'b0;
  endtask

  initial begin
    rst_in = 1'b0; update_in = 1'b0; fetch_pc_in = '0;
    exmem_pc_in = '0; exmem_taken_in = 1'b0; exmem_target_in = '0;
    @(posedge clk_in); #1;
    do_reset();

    look("rst", 32'h1040, 0, 0, 32'h0);

    // Allocation at weakly-taken; pc[1:0] ignored; neighbouring set unaffected.
    upd(32'h1040, 1, 32'h2000);
    look("alloc",     32'h1040, 1, 1, 32'h2000);
    look("alloc_lsb", 32'h1043, 1, 1, 32'h2000);
    look("other_set", 32'h1044, 0, 0, 32'h0);

    upd(32'h3040, 0, 32'h5555);
    look("nt_miss", 32'h3040, 0, 0, 32'h0);

    // Counter 2 -> 1 -> 0 -> 0; not-taken leaves the target alone.
    upd(32'h1040, 0, 32'h7777);
    look("nt1", 32'h1040, 1, 0, 32'h2000);
    upd(32'h1040, 0, 32'h7777);
    upd(32'h1040, 0, 32'h7777);
    look("nt3", 32'h1040, 1, 0, 32'h2000);

    // 0 -> 1 -> 2 -> 3 -> 3, taken overwrites the target.
    upd(32'h1040, 1, 32'h2400);
    look("t1", 32'h1040, 1, 0, 32'h2400);
    upd(32'h1040, 1, 32'h2400);
    upd(32'h1040, 1, 32'h2400);
    upd(32'h1040, 1, 32'h2400);
    look("t4", 32'h1040, 1, 1, 32'h2400);
    upd(32'h1040, 0, 32'h0);
    look("sat_nt1", 32'h1040, 1, 1, 32'h2400);
    upd(32'h1040, 0, 32'h0);
    look("sat_nt2", 32'h1040, 1, 0, 32'h2400);

    // LRU: the hit-update on 0x1040 leaves 0x2040's way as victim.
    do_reset();
    look("rst2", 32'h1040, 0, 0, 32'h0);
    upd(32'h1040, 1, 32'h1111);
    upd(32'h2040, 1, 32'h2222);
    look("two_a", 32'h1040, 1, 1, 32'h1111);
    look("two_b", 32'h2040, 1, 1, 32'h2222);
    upd(32'h1040, 1, 32'h1112);
    upd(32'h3040, 1, 32'h3333);
    look("lru_evict", 32'h2040, 0, 0, 32'h0);
    look("lru_keep",  32'h1040, 1, 1, 32'h1112);
    look("lru_new",   32'h3040, 1, 1, 32'h3333);

    // Read-before-write on the same entry.
    do_reset();
    fetch_pc_in     = 32'h1040;
    update_in       = 1'b1;
    exmem_pc_in     = 32'h1040;
    exmem_taken_in  = 1'b1;
    exmem_target_in = 32'h4000;
    #1;
    chk("rbw.same_cycle", 32'(fetch_hit_out), 32'd0);
    @(posedge clk_in); #1;
    update_in = 1'b0;
    look("rbw.next", 32'h1040, 1, 1, 32'h4000);

    // Update coinciding with reset is dropped and earlier entries are gone.
    rst_in          = 1'b1;
    update_in       = 1'b1;
    exmem_pc_in     = 32'h2040;
    exmem_taken_in  = 1'b1;
    exmem_target_in = 32'h6000;
    @(posedge clk_in); #1;
    rst_in = 1'b0; update_in = 1'b0;
    look("rst_drop_a", 32'h2040, 0, 0, 32'h0);
    look("rst_drop_b", 32'h1040, 0, 0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bp_btb.md
Name: bp_btb

Overview:
- Parametrised successor to the tag-only branch history table.
- Set-associative branch target buffer: per entry it holds a valid bit, a tag, a branch target and a 2-bit saturating direction counter.
- The fetch stage reads it combinationally and gets hit, predicted direction and target in the same cycle.
- The EX/MEM stage trains it on resolved branches; training takes effect at the next rising clock edge.

Parameters:
- PC, 32: address width in bits.
- INDEX_BITS, 5: set index width; the table has 2**INDEX_BITS sets.
- WAYS, 2: associativity; legal values are 1 or 2.
- CTR_INIT, 2'b10: counter value written on allocation (weakly taken).

Ports:
- clk_in  input  1  clock; all state changes on the rising edge.
- rst_in  input  1  synchronous, active-high reset.
- fetch_pc_in  input  PC  fetch address to look up.
- fetch_hit_out  output  1  a valid entry matches fetch_pc_in.
- fetch_taken_out  output  1  predicted taken: hit AND counter bit [1].
- fetch_target_out  output  PC  stored target on hit; 0 on miss.
- update_in  input  1  a resolved conditional branch is present at EX/MEM.
- exmem_pc_in  input  PC  address of the resolved branch.
- exmem_taken_in  input  1  actual branch outcome.
- exmem_target_in  input  PC  actual branch target.

Behaviour:
- Address split: index = pc[INDEX_BITS+1:2]; tag = pc[PC-1:INDEX_BITS+2]. TAGW = PC-INDEX_BITS-2. pc[1:0] is ignored.
- Storage: tag, target and counter arrays have no reset. Valid bits and per-set LRU bits are flops.
- Reset:
  - While rst_in is high at a rising edge, all valid bits clear and all LRU bits go to 0 in that single cycle.
  - update_in is ignored in that cycle.
  - fetch outputs are 0 from the following cycle until an allocation occurs.
- Lookup (combinational, zero latency):
  - A way hits when its valid bit is set and its tag equals the fetch tag.
  - At most one way can hit, because allocation never duplicates a tag.
  - fetch_target_out and fetch_taken_out are 0 when fetch_hit_out is 0.
- Update (rising edge, update_in=1, rst_in=0), on a hit in way w:
  - Counter: +1 if taken, saturating at 3; -1 if not taken, saturating at 0.
  - If taken, target[w] is overwritten with exmem_target_in.
  - LRU[set] points to the way other than w.
- Update on a miss with exmem_taken_in=1 (allocate):
  - Victim is the lowest-numbered invalid way; if all ways are valid, the victim is LRU[set].
  - Victim gets valid=1, tag, target = exmem_target_in, counter = CTR_INIT.
  - LRU[set] points to the other way.
- Update on a miss with exmem_taken_in=0: no state change.
- WAYS=1: direct-mapped; the victim is always way 0 and LRU logic is removed.
- Simultaneous fetch and update to the same set or entry:
  - Fetch sees the pre-update contents (read-before-write).
  - No bypass; the new value is visible in the next cycle.
- Fetch lookups never modify LRU.
- Illegal WAYS value: elaboration-time $error.

Decomposition:
- Package bp_pkg:
  - typedef logic [1:0] ctr_t;
  - constants CTR_MAX=3 and CTR_MIN=0;
  - functions ctr_next(ctr_t, logic taken) and idx_of / tag_of address-split helpers, parametrised by INDEX_BITS via function arguments.
- Sub-module bp_btb_way: one way's valid, tag, target and counter storage.
  - Ports: one combinational read port and one write port with per-field write enables.
  - bp_btb instantiates it WAYS times and holds the LRU bits, the victim select and the hit mux.

Test Plan (defaults; pc 0x1040 gives index 0x10, tag 0x20; 0x2040 gives index 0x10, tag 0x40; 0x3040 gives index 0x10, tag 0x60):
- Reset then lookup: rst_in=1 for one cycle, fetch 0x1040 -> hit=0, taken=0, target=0x0.
- Allocate: update 0x1040 taken, target 0x2000; next cycle fetch 0x1040 -> hit=1, taken=1, target=0x2000.
- Not-taken update on an untracked address: update 0x3040 not-taken, then fetch 0x3040 -> hit=0.
- Counter saturation:
  - Three not-taken updates to 0x1040 -> counter 0, taken=0, hit=1.
  - Then four taken updates -> counter 3; one not-taken -> taken=1.
- LRU replacement:
  - Allocate 0x1040, then 0x2040.
  - Hit-update 0x1040 taken, which makes way1 LRU.
  - Allocate 0x3040 -> 0x2040 misses; 0x1040 and 0x3040 hit.
- Same-cycle read/write: fetch 0x1040 while allocating 0x1040 -> hit=0 that cycle, hit=1 the next cycle. A reset asserted with update_in=1 -> the update is dropped and all lookups miss.
